// File: rtl/bos_pkg.sv
// Shared definitions for the byte-oriented serial link.
// This package is used by the frame encoder and by the host-side decoder model.
package bos_pkg;

    // Start-of-frame marker byte.
    localparam logic [7:0] SOF_BYTE      = 8'h55;

    // Largest payload a single frame may carry.
    localparam int         MAX_FRAME_LEN = 63;

    // Encoder states.
    // They are kept here so that the decoder model can track the same phases.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_SOF    = 3'd1,
        S_ADDR   = 3'd2,
        S_LEN    = 3'd3,
        PAY_CAP  = 3'd4,
        PAY_WAIT = 3'd5,
        S_CSUM   = 3'd6
    } enc_state_t;

    // Payload length actually framed: the fill level, capped at the frame maximum.
    function automatic logic [7:0] clamp_len(input logic [7:0] fill, input logic [7:0] max_len);
        logic [7:0] res;
        if (fill > max_len) begin
            res = max_len;
        end else begin
            res = fill;
        end
        return res;
    endfunction

    // Checksum byte: two's complement of the running sum.
    // With it, the whole frame body sums to zero mod 256.
    function automatic logic [7:0] csum_byte(input logic [7:0] running_sum);
        return 8'(8'h00 - running_sum);
    endfunction

endpackage

// File: rtl/msg_encoder.sv
// Drains a message from a non-showahead FIFO and emits it as one framed packet:
//   SOF, ADDR, LEN, payload[0..LEN-1], CSUM
// The output is a valid/ready byte stream.
// Each payload byte costs a read cycle plus an output cycle; the read latency is not hidden.
import bos_pkg::*;

module msg_encoder #(
    parameter logic [7:0] ADDR    = 8'h00,
    parameter logic [7:0] SOF     = SOF_BYTE,
    parameter int         MAX_LEN = MAX_FRAME_LEN
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       have_msg,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    output logic       rdreq,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    enc_state_t r_state;
    enc_state_t w_state;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt;
    logic [7:0] r_sum;
    logic [7:0] w_sum;
    logic [7:0] r_out_data;
    logic [7:0] w_out_data;
    logic       r_out_valid;
    logic       w_out_valid;
    logic       w_accept;
    logic       w_rdreq;

    assign w_accept = r_out_valid & out_ready;

    // State and datapath registers; reset returns to IDLE and abandons any partial frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'h00;
            r_sum       <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_sum       <= w_sum;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
        end
    end

    // Next-state and datapath logic.
    // Every field holds unless a transfer is accepted, so a stalled sink freezes the frame.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_sum       = r_sum;
        w_out_data  = r_out_data;
        w_out_valid = r_out_valid;
        case (r_state)
            IDLE: begin
                // A zero fill level is a spurious non-empty flag and is ignored.
                if (have_msg && (len != 8'h00)) begin
                    w_cnt       = clamp_len(len, MAX_LEN_B);
                    w_sum       = 8'h00;
                    w_out_data  = SOF;
                    w_out_valid = 1'b1;
                    w_state     = S_SOF;
                end else begin
                    w_state = IDLE;
                end
            end
            S_SOF: begin
                if (w_accept) begin
                    w_out_data = ADDR;
                    w_sum      = ADDR;
                    w_state    = S_ADDR;
                end else begin
                    w_state = S_SOF;
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    w_out_data = r_cnt;
                    w_sum      = 8'(r_sum + r_cnt);
                    w_state    = S_LEN;
                end else begin
                    w_state = S_ADDR;
                end
            end
            S_LEN: begin
                // The first FIFO read is issued combinationally in this accept cycle.
                if (w_accept) begin
                    w_out_valid = 1'b0;
                    w_state     = PAY_CAP;
                end else begin
                    w_state = S_LEN;
                end
            end
            PAY_CAP: begin
                // FIFO q is valid one cycle after the read strobe.
                w_out_data  = in_data;
                w_out_valid = 1'b1;
                w_sum       = 8'(r_sum + in_data);
                w_cnt       = 8'(r_cnt - 8'd1);
                w_state     = PAY_WAIT;
            end
            PAY_WAIT: begin
                if (w_accept) begin
                    if (r_cnt == 8'h00) begin
                        w_out_data = csum_byte(r_sum);
                        w_state    = S_CSUM;
                    end else begin
                        w_out_valid = 1'b0;
                        w_state     = PAY_CAP;
                    end
                end else begin
                    w_state = PAY_WAIT;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_out_valid = 1'b0;
                    w_state     = IDLE;
                end else begin
                    w_state = S_CSUM;
                end
            end
            default: begin
                w_state     = IDLE;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // FIFO read strobe.
    // It is decoded only from registered state, cnt and out_ready, so it asserts in the cycle the previous byte is accepted.
    always_comb begin
        w_rdreq = 1'b0;
        case (r_state)
            S_LEN: begin
                w_rdreq = out_ready;
            end
            PAY_WAIT: begin
                if (r_cnt != 8'h00) begin
                    w_rdreq = out_ready;
                end else begin
                    w_rdreq = 1'b0;
                end
            end
            default: begin
                w_rdreq = 1'b0;
            end
        endcase
    end

    assign rdreq     = w_rdreq;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_msg_encoder.sv
// Scoreboard testbench for msg_encoder.
// It models the source FIFO, generates expected frames from the framing rules and checks the output stream.
module tb_msg_encoder;

    localparam logic [7:0] TB_ADDR = 8'h03;
    localparam int         TB_MAX  = 63;

    logic       clk       = 1'b0;
    logic       n_rst     = 1'b0;
    logic       have_msg;
    logic [7:0] len;
    logic [7:0] in_data   = 8'h00;
    logic       rdreq;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    // Source FIFO model: test process owns the write pointer, read side owns the read pointer.
    logic [7:0] fifo_mem [4096];
    int         wr_ptr     = 0;
    int         rd_ptr     = 0;
    logic       force_have = 1'b0;

    // Expected output bytes.
    logic [7:0] exp_q [$];

    int         checks     = 0;
    int         failures   = 0;
    int         rd_seen    = 0;
    int         busy_seen  = 0;
    int         ready_mode = 0;
    logic       ready_force = 1'b1;
    logic       hold_v     = 1'b0;
    logic [7:0] hold_d     = 8'h00;

    always #5 clk = ~clk;

    assign have_msg = force_have | (wr_ptr != rd_ptr);
    assign len      = ((wr_ptr - rd_ptr) > 255) ? 8'hFF : 8'(wr_ptr - rd_ptr);

    msg_encoder #(
        .ADDR    (TB_ADDR),
        .SOF     (8'h55),
        .MAX_LEN (TB_MAX)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .have_msg  (have_msg),
        .len       (len),
        .in_data   (in_data),
        .rdreq     (rdreq),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Non-showahead FIFO read: q updates one cycle after the strobe; an empty FIFO keeps q.
    always @(posedge clk) begin
        if (rdreq && (rd_ptr != wr_ptr)) begin
            in_data <= fifo_mem[rd_ptr % 4096];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Sink ready driver.
    always @(negedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = ($urandom_range(0, 9) < 6);
            default: out_ready = ready_force;
        endcase
    end

    // Monitor: compares every accepted byte against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        #2;
        if (n_rst) begin
            if (rdreq) rd_seen++;
            if (busy) busy_seen++;
            if (hold_v && out_valid) chk("hold_stable", 32'(out_data), 32'(hold_d));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte actual=%0h required=none at %0t", out_data, $time);
                end else begin
                    chk("frame_byte", 32'(out_data), 32'(exp_q.pop_front()));
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
            end else begin
                hold_v = 1'b0;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic fifo_write(input logic [7:0] d[$]);
        foreach (d[i]) begin
            fifo_mem[wr_ptr % 4096] = d[i];
            wr_ptr++;
        end
    endtask

    // Reference model: split the message into frames of at most TB_MAX bytes.
    // Each frame gets its header and a checksum that makes the frame body sum to zero.
    task automatic send_msg(input logic [7:0] d[$]);
        int idx = 0;
        while (idx < d.size()) begin
            int take = ((d.size() - idx) > TB_MAX) ? TB_MAX : (d.size() - idx);
            int sum  = int'(TB_ADDR) + take;
            exp_q.push_back(8'h55);
            exp_q.push_back(TB_ADDR);
            exp_q.push_back(8'(take));
            for (int k = 0; k < take; k++) begin
                exp_q.push_back(d[idx + k]);
                sum += int'(d[idx + k]);
            end
            exp_q.push_back(8'((256 - (sum % 256)) % 256));
            idx += take;
        end
        fifo_write(d);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if ((exp_q.size() == 0) && !busy && (wr_ptr == rd_ptr)) break;
        end
        if (i == budget) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d_bytes_left required=0", name, exp_q.size());
        end
    endtask

    initial begin
        logic [7:0] msg[$];
        int rd0;
        int bz0;
        int total;
        int found;

        // Reset state.
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_rdreq", 32'(rdreq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Test 1: two-byte message with the sink always ready.
        // The expected bytes are written out literally.
        ready_mode = 0;
        rd0 = rd_seen;
        bz0 = busy_seen;
        exp_q.push_back(8'h55); exp_q.push_back(8'h03); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'h1A);
        msg = '{8'hA5, 8'h3C};
        fifo_write(msg);
        wait_idle(100, "t1");
        chk("t1_busy_cycles", 32'(busy_seen - bz0), 32'd8);
        chk("t1_rdreq_pulses", 32'(rd_seen - rd0), 32'd2);

        // Test 2: same frame, sink toggling every cycle.
        ready_mode = 1;
        exp_q.push_back(8'h55); exp_q.push_back(8'h03); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'h1A);
        fifo_write(msg);
        wait_idle(200, "t2");

        // Test 3: message longer than the maximum splits into back-to-back frames.
        ready_mode = 2;
        msg.delete();
        for (int i = 0; i < 70; i++) msg.push_back(8'(i + 1));
        rd0 = rd_seen;
        send_msg(msg);
        wait_idle(2000, "t3");
        chk("t3_rdreq_pulses", 32'(rd_seen - rd0), 32'd70);

        // Test 4: non-empty flag with zero fill level is ignored.
        ready_mode = 0;
        force_have = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            chk("t4_out_valid", 32'(out_valid), 32'd0);
            chk("t4_rdreq", 32'(rdreq), 32'd0);
            chk("t4_busy", 32'(busy), 32'd0);
        end
        force_have = 1'b0;
        @(negedge clk);

        // Test 5: reset asserted while a payload byte is stalled.
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #3;
            if (rdreq) begin
                found = 1;
                break;
            end
        end
        chk("t5_first_rdreq_seen", 32'(found), 32'd1);
        ready_force = 1'b0;
        ready_mode  = 3;
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("t5_pay_wait_valid", 32'(out_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_rdreq", 32'(rdreq), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        wr_ptr = rd_ptr;
        @(negedge clk);
        n_rst = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        msg.delete();
        for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        wait_idle(200, "t5");

        // Test 6: random lengths with random sink stalls.
        ready_mode = 2;
        rd0 = rd_seen;
        total = 0;
        for (int f = 0; f < 25; f++) begin
            int n = $urandom_range(1, 63);
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            total += n;
            send_msg(msg);
            wait_idle(2000, "t6");
        end
        chk("t6_rdreq_pulses", 32'(rd_seen - rd0), 32'(total));
        chk("end_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
